// File: rtl/ysyx_23060240_lsu_axi_master_if.sv
// LSU request/response channel plus AXI-lite data-side master port, bundled
// with a master view (the LSU bridge) and a slave view (LSU + memory side).
interface ysyx_23060240_lsu_axi_master_if;
  // LSU request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  // AXI-lite read channels
  logic [31:0] maxi_araddr;
  logic        maxi_arvalid;
  logic        maxi_arready;
  logic [31:0] maxi_rdata;
  logic        maxi_rvalid;
  logic        maxi_rready;

  // AXI-lite write channels and byte-mask side band
  logic [31:0] maxi_awaddr;
  logic        maxi_awvalid;
  logic        maxi_awready;
  logic [31:0] maxi_wdata;
  logic        maxi_wvalid;
  logic        maxi_wready;
  logic        maxi_bvalid;
  logic        maxi_bready;
  logic [7:0]  wmask;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata,
    output maxi_araddr, maxi_arvalid, input maxi_arready,
    input  maxi_rdata, maxi_rvalid, output maxi_rready,
    output maxi_awaddr, maxi_awvalid, input maxi_awready,
    output maxi_wdata, maxi_wvalid, input maxi_wready,
    input  maxi_bvalid, output maxi_bready,
    output wmask
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata,
    input  maxi_araddr, maxi_arvalid, output maxi_arready,
    output maxi_rdata, maxi_rvalid, input maxi_rready,
    input  maxi_awaddr, maxi_awvalid, output maxi_awready,
    input  maxi_wdata, maxi_wvalid, output maxi_wready,
    output maxi_bvalid, input maxi_bready,
    input  wmask
  );
endinterface

// File: rtl/ysyx_23060240_lsu_axi_master.sv
// AXI-lite master turning single LSU load/store requests into AR/R or AW/W/B
// transactions. Define LSU_LOAD_EXT_EN to lane-select and extend load data.
module ysyx_23060240_lsu_axi_master (
  input  logic                               clk,
  input  logic                               rst,
  ysyx_23060240_lsu_axi_master_if.master     bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;
  localparam logic [AW-1:0] RESET_ADDR = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t state, state_n;

  logic aw_done, w_done;
  logic aw_done_n, w_done_n;

  logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic          req_ready_d, arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d, resp_valid_d;
  logic [DW-1:0] load_result_c;

  assign accept = bus.req_valid  && bus.req_ready;
  assign ar_hs  = bus.maxi_arvalid && bus.maxi_arready;
  assign r_hs   = bus.maxi_rvalid  && bus.maxi_rready;
  assign aw_hs  = bus.maxi_awvalid && bus.maxi_awready;
  assign w_hs   = bus.maxi_wvalid  && bus.maxi_wready;
  assign b_hs   = bus.maxi_bvalid  && bus.maxi_bready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Next-state logic; AW and W completion tracked independently
  always_comb begin
    state_n   = state;
    aw_done_n = (state == WR_REQ) && (aw_done || aw_hs);
    w_done_n  = (state == WR_REQ) && (w_done  || w_hs);
    case (state)
      IDLE:    if (accept) state_n = bus.req_wen ? WR_REQ : RD_ADDR;
      RD_ADDR: if (ar_hs)  state_n = RD_DATA;
      RD_DATA: if (r_hs)   state_n = IDLE;
      WR_REQ:  if (aw_done_n && w_done_n) state_n = WR_RESP;
      WR_RESP: if (b_hs)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode: registered outputs follow the state being entered
  always_comb begin
    req_ready_d  = 1'b0;
    arvalid_d    = 1'b0;
    rready_d     = 1'b0;
    awvalid_d    = 1'b0;
    wvalid_d     = 1'b0;
    bready_d     = 1'b0;
    resp_valid_d = 1'b0;
    case (state_n)
      IDLE:    req_ready_d = 1'b1;
      RD_ADDR: arvalid_d   = 1'b1;
      RD_DATA: rready_d    = 1'b1;
      WR_REQ: begin
        awvalid_d = !aw_done_n;
        wvalid_d  = !w_done_n;
      end
      WR_RESP: bready_d    = 1'b1;
      default: req_ready_d = 1'b0;
    endcase
    resp_valid_d = ((state == RD_DATA) && r_hs) || ((state == WR_RESP) && b_hs);
  end

`ifdef LSU_LOAD_EXT_EN
  logic [1:0] size_q;
  logic       unsigned_q;
  logic [1:0] offset_q;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      offset_q   <= 2'd0;
    end else if (accept && !bus.req_wen) begin
      size_q     <= bus.req_size;
      unsigned_q <= bus.req_unsigned;
      offset_q   <= bus.req_addr[1:0];
    end
  end

  // Lane select by latched offset, then sign/zero extend
  always_comb begin
    lane_b = bus.maxi_rdata[8*offset_q +: 8];
    lane_h = offset_q[1] ? bus.maxi_rdata[31:16] : bus.maxi_rdata[15:0];
    case (size_q)
      2'd0:    load_result_c = unsigned_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    load_result_c = unsigned_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_result_c = bus.maxi_rdata;
    endcase
  end
`else
  logic unused_ext;
  assign unused_ext    = ^{bus.req_size, bus.req_unsigned};
  assign load_result_c = bus.maxi_rdata;
`endif

  // Output and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_ready    <= 1'b1;
      bus.maxi_arvalid <= 1'b0;
      bus.maxi_rready  <= 1'b0;
      bus.maxi_awvalid <= 1'b0;
      bus.maxi_wvalid  <= 1'b0;
      bus.maxi_bready  <= 1'b0;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.maxi_araddr  <= RESET_ADDR;
      bus.maxi_awaddr  <= RESET_ADDR;
      bus.maxi_wdata   <= '0;
      bus.wmask        <= MW'(0);
    end else begin
      bus.req_ready    <= req_ready_d;
      bus.maxi_arvalid <= arvalid_d;
      bus.maxi_rready  <= rready_d;
      bus.maxi_awvalid <= awvalid_d;
      bus.maxi_wvalid  <= wvalid_d;
      bus.maxi_bready  <= bready_d;
      bus.resp_valid   <= resp_valid_d;
      if (accept) begin
        if (bus.req_wen) begin
          bus.maxi_awaddr <= bus.req_addr;
          bus.maxi_wdata  <= bus.req_wdata;
          bus.wmask       <= bus.req_wmask;
        end else begin
          bus.maxi_araddr <= bus.req_addr;
        end
      end
      if ((state == RD_DATA) && r_hs) bus.resp_rdata <= load_result_c;
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_lsu_axi_master.sv
// Directed self-checking bench for ysyx_23060240_lsu_axi_master.
module tb_ysyx_23060240_lsu_axi_master;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ysyx_23060240_lsu_axi_master_if bus ();

  ysyx_23060240_lsu_axi_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full load with a slave that is ready immediately; ends in the response cycle
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
    bus.req_valid    = 1'b1;
    bus.req_wen      = 1'b0;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    chk({tag, "_accept_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid    = 1'b0;
    bus.maxi_arready = 1'b1;
    chk({tag, "_arvalid"}, 32'(bus.maxi_arvalid), 32'd1);
    chk({tag, "_araddr"}, bus.maxi_araddr, addr);
    chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    tick();
    bus.maxi_arready = 1'b0;
    bus.maxi_rvalid  = 1'b1;
    bus.maxi_rdata   = rdata;
    chk({tag, "_arvalid_drop"}, 32'(bus.maxi_arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(bus.maxi_rready), 32'd1);
    chk({tag, "_no_early_resp"}, 32'(bus.resp_valid), 32'd0);
    tick();
    bus.maxi_rvalid = 1'b0;
    bus.maxi_rdata  = 32'h0;
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, exp);
    chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rready_drop"}, 32'(bus.maxi_rready), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_b_s, exp_b_u, exp_h_s;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_wmask    = 8'h0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.maxi_arready = 1'b0;
    bus.maxi_rdata   = 32'h0;
    bus.maxi_rvalid  = 1'b0;
    bus.maxi_awready = 1'b0;
    bus.maxi_wready  = 1'b0;
    bus.maxi_bvalid  = 1'b0;

`ifdef LSU_LOAD_EXT_EN
    exp_b_s = 32'hFFFF_FF80;
    exp_b_u = 32'h0000_0080;
    exp_h_s = 32'hFFFF_80FF;
`else
    exp_b_s = 32'h80FF_1234;
    exp_b_u = 32'h80FF_1234;
    exp_h_s = 32'h80FF_1234;
`endif

    // Reset values
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_arvalid", 32'(bus.maxi_arvalid), 32'd0);
    chk("rst_rready", 32'(bus.maxi_rready), 32'd0);
    chk("rst_awvalid", 32'(bus.maxi_awvalid), 32'd0);
    chk("rst_wvalid", 32'(bus.maxi_wvalid), 32'd0);
    chk("rst_bready", 32'(bus.maxi_bready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_araddr", bus.maxi_araddr, 32'h8000_0000);
    chk("rst_awaddr", bus.maxi_awaddr, 32'h8000_0000);
    chk("rst_wdata", bus.maxi_wdata, 32'h0);
    chk("rst_wmask", 32'(bus.wmask), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(bus.req_ready), 32'd1);

    // Word load, then back-to-back load accepted in the response cycle
    do_load("word", 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("b2b", 32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678);
    tick();
    chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    chk("rdata_held", bus.resp_rdata, 32'h1234_5678);

    // Store: W ready immediately, AW ready two cycles late
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 32'h8000_0010;
    bus.req_wdata = 32'h0000_ABCD;
    bus.req_wmask = 8'h03;
    bus.maxi_wready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.req_wmask = 8'h00;
    chk("st_awvalid_1", 32'(bus.maxi_awvalid), 32'd1);
    chk("st_wvalid_1", 32'(bus.maxi_wvalid), 32'd1);
    chk("st_awaddr", bus.maxi_awaddr, 32'h8000_0010);
    chk("st_wdata", bus.maxi_wdata, 32'h0000_ABCD);
    chk("st_wmask", 32'(bus.wmask), 32'h03);
    tick();
    chk("st_wvalid_drop", 32'(bus.maxi_wvalid), 32'd0);
    chk("st_awvalid_2", 32'(bus.maxi_awvalid), 32'd1);
    chk("st_bready_wait", 32'(bus.maxi_bready), 32'd0);
    tick();
    bus.maxi_awready = 1'b1;
    chk("st_awvalid_3", 32'(bus.maxi_awvalid), 32'd1);
    chk("st_awaddr_stable", bus.maxi_awaddr, 32'h8000_0010);
    tick();
    bus.maxi_awready = 1'b0;
    bus.maxi_wready  = 1'b0;
    bus.maxi_bvalid  = 1'b1;
    chk("st_awvalid_drop", 32'(bus.maxi_awvalid), 32'd0);
    chk("st_bready", 32'(bus.maxi_bready), 32'd1);
    chk("st_no_early_resp", 32'(bus.resp_valid), 32'd0);
    chk("st_wmask_held", 32'(bus.wmask), 32'h03);
    tick();
    bus.maxi_bvalid = 1'b0;
    chk("st_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("st_bready_drop", 32'(bus.maxi_bready), 32'd0);
    chk("st_ready_back", 32'(bus.req_ready), 32'd1);
    tick();
    chk("st_resp_one_cycle", 32'(bus.resp_valid), 32'd0);

    // Store: AW ready first, W one cycle later
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 32'h8000_0020;
    bus.req_wdata = 32'h5555_AAAA;
    bus.req_wmask = 8'h0F;
    bus.maxi_awready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.maxi_awready = 1'b0;
    bus.maxi_wready  = 1'b1;
    chk("aw1_awvalid_drop", 32'(bus.maxi_awvalid), 32'd0);
    chk("aw1_wvalid_held", 32'(bus.maxi_wvalid), 32'd1);
    chk("aw1_wdata", bus.maxi_wdata, 32'h5555_AAAA);
    tick();
    bus.maxi_wready = 1'b0;
    bus.maxi_bvalid = 1'b1;
    chk("aw1_wvalid_drop", 32'(bus.maxi_wvalid), 32'd0);
    chk("aw1_bready", 32'(bus.maxi_bready), 32'd1);
    tick();
    bus.maxi_bvalid = 1'b0;
    chk("aw1_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("aw1_wmask", 32'(bus.wmask), 32'h0F);
    tick();

    // Sub-word loads: extension only when LSU_LOAD_EXT_EN is defined
    do_load("lb", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_1234, exp_b_s);
    do_load("lbu", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_1234, exp_b_u);
    do_load("lh", 32'h8000_0002, 2'd1, 1'b0, 32'h80FF_1234, exp_h_s);
    tick();

    // Stalled AR channel: payload stable for 20 cycles
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 32'h8000_0040;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("stall_arvalid_%0d", i), 32'(bus.maxi_arvalid), 32'd1);
      chk($sformatf("stall_araddr_%0d", i), bus.maxi_araddr, 32'h8000_0040);
      chk($sformatf("stall_busy_%0d", i), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.maxi_arready = 1'b1;
    tick();
    bus.maxi_arready = 1'b0;
    chk("stall_rready", 32'(bus.maxi_rready), 32'd1);

    // Reset while in RD_DATA, with rvalid arriving in the same cycle
    rst = 1'b1;
    bus.maxi_rvalid = 1'b1;
    bus.maxi_rdata  = 32'hCAFE_F00D;
    tick();
    rst = 1'b0;
    bus.maxi_rvalid = 1'b0;
    chk("mid_rst_rready", 32'(bus.maxi_rready), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_resp", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_araddr", bus.maxi_araddr, 32'h8000_0000);
    chk("mid_rst_rdata", bus.resp_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_resp_%0d", i), 32'(bus.resp_valid), 32'd0);
    end

    // Normal operation resumes after reset
    do_load("post_rst", 32'h8000_0100, 2'd2, 1'b0, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
